// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the 7-segment scan controller:
//   - state_t      : scan slot phase (blanking interval or driving a digit)
//   - SEG_*        : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   - pin_level()  : maps a logical "on" bit to the pin level for the chosen
//                    polarity (common anode = active-low)
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Logical "on" -> physical pin level.
    function automatic logic pin_level(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD nibble to 7-segment decoder, active-high output.
//   nibble_i : 4-bit value; 0-9 decode to digits, 10-15 decode to a dash
//   seg_o    : segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed 7-segment scan controller sharing one seg/dp bus among
// NUM_DIGITS digit drivers. Each digit slot is SCAN_DIV clocks long and begins
// with BLANK_CYCLES of all-off to avoid ghosting. New values are captured into
// a shadow register and committed to the display buffer only at the frame
// boundary (last cycle of the last digit slot), so a frame never mixes values.
// Ports:
//   clock_50MHZ, reset_n         : clock, async active-low reset
//   load, value_bcd, dp_mask     : capture request and data (nibble 0 = LSD)
//   lz_suppress                  : blank leading zeros (live input)
//   load_ack, pending            : commit pulse / value waiting for commit
//   digit_en, seg, dp            : registered pin outputs (polarity ACTIVE_LOW)
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clock_50MHZ,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_suppress,
    output logic                    load_ack,
    output logic                    pending,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int   PRE_W = $clog2(SCAN_DIV);
    localparam int   IDX_W = $clog2(NUM_DIGITS);
    localparam logic OFF   = pin_level(1'b0, ACTIVE_LOW);

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q, disp_bcd_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, disp_dp_q;
    logic                    pending_q, ack_q;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    slot_end, frame_end;
    logic [3:0]              nibble;
    logic [6:0]              seg_pat;
    logic                    lz_blank, zero_run;
    logic [NUM_DIGITS-1:0]   en_act;
    logic [6:0]              seg_act;
    logic                    dp_act;

    // Prescaler / digit index / phase next-state. The phase is registered
    // alongside the prescaler so the outputs can be driven from registers.
    always_comb begin
        slot_end  = (presc_q == PRE_W'(SCAN_DIV - 1));
        frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        presc_d   = slot_end ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end
        state_d   = (presc_d < PRE_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
    end

    assign nibble = disp_bcd_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (seg_pat)
    );

    // Walk from the most significant digit down: the current digit is a
    // leading zero when it and every digit above it are zero. Digit 0 is
    // excluded so a value of 0 still shows one '0'.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (disp_bcd_q[4*k +: 4] == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                lz_blank = lz_suppress && zero_run;
            end
        end
    end

    // Logical (active-high) view of the pins for the current phase/digit.
    always_comb begin
        en_act  = '0;
        seg_act = '0;
        dp_act  = 1'b0;
        if (state_q == ST_DRIVE) begin
            en_act[idx_q] = 1'b1;
            seg_act       = lz_blank ? 7'd0 : seg_pat;
            dp_act        = disp_dp_q[idx_q];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_en_level
            assign digit_en_d[gi] = pin_level(en_act[gi], ACTIVE_LOW);
        end
        for (gi = 0; gi < 7; gi++) begin : g_seg_level
            assign seg_d[gi] = pin_level(seg_act[gi], ACTIVE_LOW);
        end
    endgenerate
    assign dp_d = pin_level(dp_act, ACTIVE_LOW);

    always_ff @(posedge clock_50MHZ or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            state_q      <= ST_BLANK;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            disp_bcd_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            ack_q        <= 1'b0;
            digit_en_q   <= {NUM_DIGITS{OFF}};
            seg_q        <= {7{OFF}};
            dp_q         <= OFF;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            ack_q      <= 1'b0;

            if (frame_end) begin
                // A load landing on the boundary skips the shadow entirely
                // and also supersedes any older pending value.
                if (load) begin
                    disp_bcd_q <= value_bcd;
                    disp_dp_q  <= dp_mask;
                    pending_q  <= 1'b0;
                    ack_q      <= 1'b1;
                end else if (pending_q) begin
                    disp_bcd_q <= shadow_bcd_q;
                    disp_dp_q  <= shadow_dp_q;
                    pending_q  <= 1'b0;
                    ack_q      <= 1'b1;
                end
            end else if (load) begin
                shadow_bcd_q <= value_bcd;
                shadow_dp_q  <= dp_mask;
                pending_q    <= 1'b1;
            end
        end
    end

    assign load_ack = ack_q;
    assign pending  = pending_q;
    assign digit_en = digit_en_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2, ACTIVE_LOW=1. Cycle n counts rising edges since reset
// release; outputs after edge n reflect prescaler (n-1)%8 and digit
// ((n-1)/8)%4, so digit k of the frame starting at edge F is shown at F+4+8k.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam logic [6:0] L0     = 7'b1000000;
    localparam logic [6:0] L1     = 7'b1111001;
    localparam logic [6:0] L2     = 7'b0100100;
    localparam logic [6:0] L3     = 7'b0110000;
    localparam logic [6:0] L4     = 7'b0011001;
    localparam logic [6:0] L5     = 7'b0010010;
    localparam logic [6:0] L8     = 7'b0000000;
    localparam logic [6:0] LDASH  = 7'b0111111;
    localparam logic [6:0] SEGOFF = 7'h7F;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [15:0] value_bcd;
    logic [3:0]  dp_mask;
    logic        lz_suppress;
    logic        load_ack;
    logic        pending;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic        dp;

    int checks    = 0;
    int failures  = 0;
    int n         = 0;
    int ack_seen  = 0;
    int ack_base  = 0;

    display_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clock_50MHZ (clk),
        .reset_n     (reset_n),
        .load        (load),
        .value_bcd   (value_bcd),
        .dp_mask     (dp_mask),
        .lz_suppress (lz_suppress),
        .load_ack    (load_ack),
        .pending     (pending),
        .digit_en    (digit_en),
        .seg         (seg),
        .dp          (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        if (load_ack === 1'b1) ack_seen++;
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic do_load(input logic [15:0] val, input logic [3:0] dpm);
        value_bcd = val;
        dp_mask   = dpm;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    task automatic check_digit(input int base, input int k, input logic [3:0] en,
                               input logic [6:0] s, input logic d, input string tag);
        run_to(base + 4 + 8 * k);
        chk({tag, " digit_en"}, 32'(digit_en), 32'(en));
        chk({tag, " seg"},      32'(seg),      32'(s));
        chk({tag, " dp"},       32'(dp),       32'(d));
        $display("n=%0d %s digit_en=%b seg=%b dp=%b", n, tag, digit_en, seg, dp);
    endtask

    initial begin
        reset_n     = 1'b0;
        load        = 1'b0;
        value_bcd   = '0;
        dp_mask     = '0;
        lz_suppress = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst digit_en", 32'(digit_en), 32'h0000000F);
        chk("rst seg",      32'(seg),      32'h0000007F);
        chk("rst dp",       32'(dp),       32'h1);
        chk("rst load_ack", 32'(load_ack), 32'h0);
        chk("rst pending",  32'(pending),  32'h0);
        $display("reset: digit_en=%b seg=%b dp=%b ack=%b pending=%b", digit_en, seg, dp, load_ack, pending);
        reset_n  = 1'b1;
        n        = 0;
        ack_seen = 0;

        // 1: idle scan for two frames, value 0
        for (int i = 1; i <= 64; i++) begin
            logic [3:0] en_exp;
            logic [6:0] seg_exp;
            tick();
            if (((n - 1) % 8) >= 2) begin
                en_exp  = ~(4'b0001 << (((n - 1) / 8) % 4));
                seg_exp = L0;
            end else begin
                en_exp  = 4'hF;
                seg_exp = SEGOFF;
            end
            chk($sformatf("idle n=%0d {en,seg,dp,ack}", n),
                {19'd0, en_exp, seg_exp, 1'b1, 1'b0},
                {19'd0, digit_en, seg, dp, load_ack});
        end
        $display("idle scan: 64 cycles checked, last digit_en=%b", digit_en);

        // 2: load 0x1234 mid-frame, commit at next frame boundary
        run_to(70);
        do_load(16'h1234, 4'b0010);
        chk("t2 pending after load", 32'(pending), 32'h1);
        while (n < 95) begin
            tick();
            chk($sformatf("t2 wait n=%0d {pending,ack}", n), {30'd0, pending, load_ack}, 32'h2);
        end
        tick();
        chk("t2 ack at boundary",     32'(load_ack), 32'h1);
        chk("t2 pending at boundary", 32'(pending),  32'h0);
        $display("n=%0d t2 commit: ack=%b pending=%b", n, load_ack, pending);
        tick();
        chk("t2 ack one cycle", 32'(load_ack), 32'h0);
        check_digit(96, 0, 4'b1110, L4, 1'b1, "t2 d0");
        run_to(106);
        chk("t2 blank digit_en", 32'(digit_en), 32'hF);
        chk("t2 blank dp",       32'(dp),       32'h1);
        check_digit(96, 1, 4'b1101, L3, 1'b0, "t2 d1");
        check_digit(96, 2, 4'b1011, L2, 1'b1, "t2 d2");
        check_digit(96, 3, 4'b0111, L1, 1'b1, "t2 d3");

        // 3: 0x0050 with leading-zero suppression, then without
        run_to(130);
        lz_suppress = 1'b1;
        do_load(16'h0050, 4'b0000);
        check_digit(160, 0, 4'b1110, L0,     1'b1, "t3 lz d0");
        check_digit(160, 1, 4'b1101, L5,     1'b1, "t3 lz d1");
        check_digit(160, 2, 4'b1011, SEGOFF, 1'b1, "t3 lz d2");
        check_digit(160, 3, 4'b0111, SEGOFF, 1'b1, "t3 lz d3");
        run_to(200);
        lz_suppress = 1'b0;
        check_digit(192, 2, 4'b1011, L0, 1'b1, "t3 nolz d2");
        check_digit(192, 3, 4'b0111, L0, 1'b1, "t3 nolz d3");

        // 4: two loads before one boundary; last wins, single ack
        run_to(226);
        ack_base = ack_seen;
        do_load(16'h1111, 4'b0000);
        run_to(230);
        do_load(16'h2222, 4'b0000);
        run_to(258);
        chk("t4 ack count", 32'(ack_seen - ack_base), 32'd1);
        $display("n=%0d t4 acks=%0d", n, ack_seen - ack_base);
        check_digit(256, 0, 4'b1110, L2, 1'b1, "t4 d0");
        check_digit(256, 2, 4'b1011, L2, 1'b1, "t4 d2");

        // 4b: load coincident with the boundary cycle bypasses the shadow
        run_to(287);
        do_load(16'h5678, 4'b0000);
        chk("t4b ack",     32'(load_ack), 32'h1);
        chk("t4b pending", 32'(pending),  32'h0);
        $display("n=%0d t4b bypass: ack=%b pending=%b", n, load_ack, pending);
        tick();
        chk("t4b pending later", 32'(pending), 32'h0);
        check_digit(288, 0, 4'b1110, L8, 1'b1, "t4b d0");
        check_digit(288, 3, 4'b0111, L5, 1'b1, "t4b d3");

        // 5: 0x00AF shows dashes for non-BCD nibbles
        run_to(300);
        do_load(16'h00AF, 4'b0000);
        check_digit(320, 0, 4'b1110, LDASH, 1'b1, "t5 d0");
        check_digit(320, 1, 4'b1101, LDASH, 1'b1, "t5 d1");
        check_digit(320, 2, 4'b1011, L0,    1'b1, "t5 d2");

        // 6: asynchronous reset while driving with a pending value
        run_to(354);
        do_load(16'h9999, 4'b1111);
        chk("t6 pending before reset", 32'(pending), 32'h1);
        run_to(357);
        chk("t6 driving before reset", 32'(digit_en), 32'hE);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6 async digit_en", 32'(digit_en), 32'hF);
        chk("t6 async seg",      32'(seg),      32'h7F);
        chk("t6 async dp",       32'(dp),       32'h1);
        chk("t6 async pending",  32'(pending),  32'h0);
        chk("t6 async ack",      32'(load_ack), 32'h0);
        $display("t6 reset asserted: digit_en=%b seg=%b dp=%b pending=%b", digit_en, seg, dp, pending);
        tick();
        tick();
        tick();
        reset_n = 1'b1;
        n       = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk($sformatf("t6 post n=%0d {pending,ack}", n), {30'd0, pending, load_ack}, 32'h0);
            if (n == 1) chk("t6 n1 digit_en", 32'(digit_en), 32'hF);
            if (n == 2) chk("t6 n2 digit_en", 32'(digit_en), 32'hF);
            if (n == 3) chk("t6 n3 digit_en", 32'(digit_en), 32'hE);
            if (n == 4) begin
                chk("t6 n4 seg", 32'(seg), 32'(L0));
                chk("t6 n4 dp",  32'(dp),  32'h1);
            end
        end
        $display("t6 restart: 40 cycles checked after release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed 7-segment scan controller. It shares one segment/decimal-point bus among NUM_DIGITS digit drivers.
- An internal prescaler divides clock_50MHZ down to a per-digit slot rate. Each slot starts with a blanking interval that prevents ghosting.
- New display values are double-buffered behind a load/ack handshake, so a digit never changes mid-frame.
- Sits between the counter/BCD logic and the board's display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned (2..8).
- SCAN_DIV, 50000: clock cycles per digit slot (≥ BLANK_CYCLES+2).
- BLANK_CYCLES, 500: cycles at the start of each slot with all digits off.
- ACTIVE_LOW, 1: 1 = seg, dp and digit_en are active-low (common anode); 0 = active-high.

Ports:
- clock_50MHZ  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle request to capture value_bcd/dp_mask.
- value_bcd  in  4*NUM_DIGITS  BCD nibbles; nibble 0 = least significant digit.
- dp_mask  in  NUM_DIGITS  decimal point enable per digit.
- lz_suppress  in  1  1 = blank leading zeros; sampled live.
- load_ack  out  1  one-cycle pulse when the buffered value is committed to the display.
- pending  out  1  a captured value awaits commit.
- digit_en  out  NUM_DIGITS  one-hot digit select (polarity per ACTIVE_LOW).
- seg  out  7  segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW).
- dp  out  1  decimal point (polarity per ACTIVE_LOW).

Behaviour:
- Reset (async assert, sync-released by the first clock edge):
  - prescaler=0, idx=0, state=BLANK.
  - display buffer=0, pending=0, load_ack=0.
  - digit_en, seg, dp all at inactive level.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - At wrap, idx increments modulo NUM_DIGITS. The wrap from idx NUM_DIGITS-1 to 0 is the frame boundary.
- State machine (two states, derived from the prescaler):
  - BLANK while prescaler < BLANK_CYCLES.
  - DRIVE while prescaler ≥ BLANK_CYCLES.
  - BLANK→DRIVE at prescaler==BLANK_CYCLES. DRIVE→BLANK at wrap.
- Outputs are registered; they reflect the previous cycle's state/idx, giving 1-cycle latency.
  - In BLANK: all digit_en inactive; seg and dp inactive.
  - In DRIVE: only digit_en[idx] active; seg = decode(buffer nibble idx); dp = dp_mask_buf[idx].
- Decode:
  - 0-9 map to the standard patterns.
  - Nibbles 10-15 show a dash (g only).
- Leading-zero suppression (lz_suppress=1):
  - Digit k > 0 is blanked when its nibble and all more significant nibbles are 0.
  - When blanked, digit_en stays active but seg is all inactive; dp still follows dp_mask.
  - Digit 0 is never blanked.
- Handshake:
  - load=1 captures value_bcd/dp_mask into a shadow register and sets pending=1.
  - A later load before commit overwrites the shadow (last wins).
  - At the frame-boundary cycle with pending=1: the shadow is copied to the display buffer, pending clears, and load_ack pulses high for exactly 1 cycle.
  - If load arrives in the frame-boundary cycle itself: the inputs bypass the shadow directly into the display buffer, load_ack pulses, and pending stays 0.
- Reset mid-frame: everything returns to reset values immediately; a pending value is discarded and no ack is issued.
- lz_suppress changes take effect on the next registered output cycle. No glitch to digit_en is allowed.

Decomposition:
- Package display_pkg:
  - state enum {ST_BLANK, ST_DRIVE}.
  - SEG_0..SEG_9 and SEG_DASH constants (active-high, {g..a}).
  - Helper for the active-level inversion.
- Sub-module seg7_decode: combinational, 4-bit nibble → 7-bit active-high pattern.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1.
1. Reset, then idle 64 cycles.
   - digit_en cycles 1110→1101→1011→0111.
   - Each digit is active 6 cycles, then all 1111 for 2 cycles.
   - seg=7'b1000000 ('0', active-low) while driven. load_ack stays 0.
2. Load 0x1234, dp_mask=0010 mid-frame.
   - pending=1 until the next idx 3→0 wrap; load_ack pulses once there.
   - Afterwards digit 0 shows '4' (7'b0011001), digit 3 shows '1'.
   - dp is low (active) only while digit 1 is driven.
3. Load 0x0050 with lz_suppress=1.
   - Digits 3 and 2 are active but with seg=7'h7F; digits 1 and 0 show '5' and '0'.
   - With lz_suppress=0, digits 3 and 2 show '0'.
4. Two loads (0x1111, then 0x2222) before a boundary.
   - One load_ack; display shows 2222.
   - Separately: load coincident with the boundary cycle → committed that cycle, pending never rises.
5. Load 0x00AF.
   - Digits 1 and 0 show dash (seg=7'b0111111).
6. Assert reset_n=0 mid-DRIVE with pending=1.
   - Outputs go inactive asynchronously.
   - After release: buffer 0, pending 0, no ack, scan restarts at digit 0 with blanking.
